dsp_test_sequencer: RTL and testbench
=====================================

Name: dsp_test_sequencer

Overview:
Synthesizable self-check controller for DSP datapath blocks. Reads stimulus/expected pairs from a vector memory and issues each stimulus to the DUT over a valid/ready handshake. Waits for the DUT result with a timeout, compares it against the expected value, and keeps pass/fail counts. Sits between the vector ROM and the DUT; benches and FPGA bring-up read its done/pass/fail instead of simulation-only tasks.

Parameters:
DATA_WIDTH, 32, width of stimulus, expected and result words
ADDR_WIDTH, 6, vector memory address width
NUM_TESTS, 16, vectors per run (0..2**ADDR_WIDTH)
TIMEOUT_CYCLES, 1024, max cycles in WAIT_RES before abort
CNT_WIDTH, 16, width of test/fail counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin run (sampled in IDLE or DONE only)
vec_addr  out  ADDR_WIDTH  vector memory address (registered)
vec_stim  in  DATA_WIDTH  stimulus word, valid 1 cycle after vec_addr
vec_expected  in  DATA_WIDTH  expected word, valid 1 cycle after vec_addr
dut_valid  out  1  stimulus valid
dut_data  out  DATA_WIDTH  stimulus to DUT
dut_ready  in  1  DUT accepts stimulus
res_valid  in  1  DUT result valid (single-cycle pulse)
res_data  in  DATA_WIDTH  DUT result
busy  out  1  run in progress
done  out  1  run finished (level, held until start/rst)
pass  out  1  done & all NUM_TESTS ran & fail_count==0
fail  out  1  done & !pass
timeout_flag  out  1  run aborted by timeout
test_count  out  CNT_WIDTH  vectors checked this run
fail_count  out  CNT_WIDTH  mismatches + timeouts this run
last_fail_index  out  ADDR_WIDTH  index of most recent failure

Behaviour:
- Reset: state IDLE; all outputs 0; internal index, stim/expected registers 0.
- States: IDLE, FETCH, LOAD, ISSUE, WAIT_RES, CHECK, DONE.
- IDLE/DONE + start: clear counters, flags, index, done; if NUM_TESTS==0 go to DONE (pass=1); otherwise go to FETCH. busy=1 in every state except IDLE/DONE.
- FETCH (1 cycle): vec_addr=index. LOAD (1 cycle): capture vec_stim/vec_expected into registers.
- ISSUE: dut_valid=1, dut_data=stim register, both held stable until dut_valid&dut_ready. Then go to WAIT_RES and deassert dut_valid the next cycle. No cap on the ready wait.
- WAIT_RES: timer starts at 0 on entry and increments each cycle. res_valid is sampled only in WAIT_RES; the handshake cycle does not count. On res_valid, latch res_data and go to CHECK. If the timer reaches TIMEOUT_CYCLES-1 without res_valid: fail_count+1, test_count+1, last_fail_index=index, timeout_flag=1, go to DONE.
- res_valid and timer expiry in the same cycle: the result wins and there is no timeout.
- CHECK (1 cycle): test_count+1. If latched result != expected: fail_count+1 and last_fail_index=index. Then index+1; index==NUM_TESTS -> DONE, else FETCH.
- res_valid outside WAIT_RES is ignored and changes no counters.
- Counters saturate at all-ones.
- Best case per vector is 5 cycles (dut_ready=1, result the cycle after the handshake).
- DONE: done=1, and pass/fail are valid. start while busy is ignored.
- rst mid-run: immediate return to the reset state; any partial results are discarded.

Test Plan:
- NUM_TESTS=4, identity DUT (ready=1, result one cycle after handshake), expected=stimulus -> done after 1+4*5 cycles, pass=1, test_count=4, fail_count=0.
- Same setup with expected[2] corrupted (0xDEADBEEF vs 0x00000002) -> pass=0, fail=1, fail_count=1, last_fail_index=2, all 4 vectors run.
- DUT holds dut_ready low 7 cycles on vector 1 -> dut_valid and dut_data stay stable for 8 cycles, exactly one handshake, result still pass.
- TIMEOUT_CYCLES=8, DUT never responds to vector 3 -> DONE after 8 WAIT_RES cycles, timeout_flag=1, test_count=4, fail_count=1, last_fail_index=3.
- res_valid on the exact expiry cycle -> no timeout, vector checked normally. Spurious res_valid pulse in ISSUE -> counters unchanged.
- rst asserted while in WAIT_RES of vector 2 -> next cycle all outputs 0, state IDLE. start after DONE -> counters clear and a full rerun passes. NUM_TESTS=0 + start -> DONE with pass=1 in 1 cycle.

Source files
------------

// File: rtl/dsp_test_sequencer.sv
// Self-check controller: walks a stimulus/expected vector memory, drives each stimulus
// into a DSP block over valid/ready, waits (with timeout) for its result and tallies pass/fail.
module dsp_test_sequencer #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 6,
    parameter int NUM_TESTS      = 16,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] vec_addr,
    input  logic [DATA_WIDTH-1:0] vec_stim,
    input  logic [DATA_WIDTH-1:0] vec_expected,
    output logic                  dut_valid,
    output logic [DATA_WIDTH-1:0] dut_data,
    input  logic                  dut_ready,
    input  logic                  res_valid,
    input  logic [DATA_WIDTH-1:0] res_data,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic                  timeout_flag,
    output logic [CNT_WIDTH-1:0]  test_count,
    output logic [CNT_WIDTH-1:0]  fail_count,
    output logic [ADDR_WIDTH-1:0] last_fail_index
);

    // The index must be able to hold NUM_TESTS itself (up to 2**ADDR_WIDTH).
    localparam int IDX_WIDTH = ADDR_WIDTH + 1;
    localparam int TMR_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [IDX_WIDTH-1:0] NUM_TESTS_IDX = IDX_WIDTH'(NUM_TESTS);
    localparam logic [CNT_WIDTH-1:0] NUM_TESTS_CNT = CNT_WIDTH'(NUM_TESTS);
    localparam logic [TMR_WIDTH-1:0] TIMER_LAST    = TMR_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam bit                   NO_TESTS      = (NUM_TESTS == 0);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        ISSUE,
        WAIT_RES,
        CHECK,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [IDX_WIDTH-1:0]  index_q, index_d;
    logic [ADDR_WIDTH-1:0] vec_addr_q, vec_addr_d;
    logic [DATA_WIDTH-1:0] stim_q, stim_d;
    logic [DATA_WIDTH-1:0] expected_q, expected_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [TMR_WIDTH-1:0]  timer_q, timer_d;
    logic [CNT_WIDTH-1:0]  test_count_q, test_count_d;
    logic [CNT_WIDTH-1:0]  fail_count_q, fail_count_d;
    logic [ADDR_WIDTH-1:0] last_fail_q, last_fail_d;
    logic                  timeout_q, timeout_d;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_WIDTH'(1);
    endfunction

    // NOTE: every variable gets a default before the case statement, so no path
    // through this block leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        vec_addr_d   = vec_addr_q;
        stim_d       = stim_q;
        expected_d   = expected_q;
        result_d     = result_q;
        timer_d      = timer_q;
        test_count_d = test_count_q;
        fail_count_d = fail_count_q;
        last_fail_d  = last_fail_q;
        timeout_d    = timeout_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    index_d      = '0;
                    vec_addr_d   = '0;
                    test_count_d = '0;
                    fail_count_d = '0;
                    last_fail_d  = '0;
                    timeout_d    = 1'b0;
                    state_d      = NO_TESTS ? DONE : FETCH;
                end
            end

            FETCH: begin
                state_d = LOAD;
            end

            // Memory data for vec_addr arrives one cycle after FETCH.
            LOAD: begin
                stim_d     = vec_stim;
                expected_d = vec_expected;
                state_d    = ISSUE;
            end

            ISSUE: begin
                if (dut_ready) begin
                    timer_d = '0;
                    state_d = WAIT_RES;
                end
            end

            // A result on the final timer cycle still counts as a response.
            WAIT_RES: begin
                if (res_valid) begin
                    result_d = res_data;
                    state_d  = CHECK;
                end else if (timer_q == TIMER_LAST) begin
                    test_count_d = sat_inc(test_count_q);
                    fail_count_d = sat_inc(fail_count_q);
                    last_fail_d  = index_q[ADDR_WIDTH-1:0];
                    timeout_d    = 1'b1;
                    state_d      = DONE;
                end else begin
                    timer_d = timer_q + TMR_WIDTH'(1);
                end
            end

            CHECK: begin
                test_count_d = sat_inc(test_count_q);
                if (result_q != expected_q) begin
                    fail_count_d = sat_inc(fail_count_q);
                    last_fail_d  = index_q[ADDR_WIDTH-1:0];
                end
                index_d = index_q + IDX_WIDTH'(1);
                if (index_d == NUM_TESTS_IDX) begin
                    state_d = DONE;
                end else begin
                    vec_addr_d = index_d[ADDR_WIDTH-1:0];
                    state_d    = FETCH;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // Datapath registers are reset too: their values appear on outputs.
            state_q      <= IDLE;
            index_q      <= '0;
            vec_addr_q   <= '0;
            stim_q       <= '0;
            expected_q   <= '0;
            result_q     <= '0;
            timer_q      <= '0;
            test_count_q <= '0;
            fail_count_q <= '0;
            last_fail_q  <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            vec_addr_q   <= vec_addr_d;
            stim_q       <= stim_d;
            expected_q   <= expected_d;
            result_q     <= result_d;
            timer_q      <= timer_d;
            test_count_q <= test_count_d;
            fail_count_q <= fail_count_d;
            last_fail_q  <= last_fail_d;
            timeout_q    <= timeout_d;
        end
    end

    assign vec_addr        = vec_addr_q;
    assign dut_valid       = (state_q == ISSUE);
    assign dut_data        = stim_q;
    assign busy            = (state_q != IDLE) && (state_q != DONE);
    assign done            = (state_q == DONE);
    assign pass            = done && (test_count_q == NUM_TESTS_CNT) && (fail_count_q == '0);
    assign fail            = done && !pass;
    assign timeout_flag    = timeout_q;
    assign test_count      = test_count_q;
    assign fail_count      = fail_count_q;
    assign last_fail_index = last_fail_q;

endmodule

// File: tb/tb_dsp_test_sequencer.sv
// Bench for dsp_test_sequencer: vector ROM and DSP-block models, a table of runs with
// expected end status, a scoreboard of issued stimuli, plus reset and zero-test sequences.
module tb_dsp_test_sequencer;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] vec_addr;
    logic [DW-1:0] vec_stim;
    logic [DW-1:0] vec_expected;
    logic          dut_valid;
    logic [DW-1:0] dut_data;
    logic          dut_ready = 1'b1;
    logic          res_valid = 1'b0;
    logic [DW-1:0] res_data = '0;
    logic          busy, done, pass, fail, timeout_flag;
    logic [CW-1:0] test_count, fail_count;
    logic [AW-1:0] last_fail_index;

    logic          z_start = 1'b0;
    logic [AW-1:0] z_vec_addr;
    logic          z_dut_valid;
    logic [DW-1:0] z_dut_data;
    logic          z_busy, z_done, z_pass, z_fail, z_timeout;
    logic [CW-1:0] z_test_count, z_fail_count;
    logic [AW-1:0] z_last_fail;

    dsp_test_sequencer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_TESTS(4), .TIMEOUT_CYCLES(8), .CNT_WIDTH(CW)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .vec_addr(vec_addr), .vec_stim(vec_stim), .vec_expected(vec_expected),
        .dut_valid(dut_valid), .dut_data(dut_data), .dut_ready(dut_ready),
        .res_valid(res_valid), .res_data(res_data),
        .busy(busy), .done(done), .pass(pass), .fail(fail), .timeout_flag(timeout_flag),
        .test_count(test_count), .fail_count(fail_count), .last_fail_index(last_fail_index)
    );

    dsp_test_sequencer #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_TESTS(0), .TIMEOUT_CYCLES(8), .CNT_WIDTH(CW)
    ) u_zero (
        .clk(clk), .rst(rst), .start(z_start),
        .vec_addr(z_vec_addr), .vec_stim('0), .vec_expected('0),
        .dut_valid(z_dut_valid), .dut_data(z_dut_data), .dut_ready(1'b1),
        .res_valid(1'b0), .res_data('0),
        .busy(z_busy), .done(z_done), .pass(z_pass), .fail(z_fail), .timeout_flag(z_timeout),
        .test_count(z_test_count), .fail_count(z_fail_count), .last_fail_index(z_last_fail)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Synchronous vector ROM: data follows the address by one clock.
    logic [DW-1:0] rom_stim [64];
    logic [DW-1:0] rom_exp  [64];
    always @(posedge clk) begin
        vec_stim     <= rom_stim[vec_addr];
        vec_expected <= rom_exp[vec_addr];
    end

    // DSP block model, driven on the falling edge. Configured per run.
    int            stall_vec = -1, stall_cycles = 0;
    int            delay_vec = -1, delay_len = 0;
    int            spur_vec = -1;
    int            hs_idx = 0, valid_cycles = 0, pend_cnt = 0;
    bit            just_hs = 1'b0;
    logic [DW-1:0] pend_data = '0, held_data = '0;
    logic [DW-1:0] sb_q [$];

    always @(negedge clk) begin
        res_valid = 1'b0;
        if (just_hs) begin
            check("valid_drop_after_hs", dut_valid, 1'b0);
            just_hs = 1'b0;
        end
        if (pend_cnt > 0) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
                res_valid = 1'b1;
                res_data  = pend_data;
            end
        end
        dut_ready = 1'b1;
        if (dut_valid) begin
            if (valid_cycles > 0) check("stim_stable", dut_data, held_data);
            held_data = dut_data;
            valid_cycles++;
            if (hs_idx == stall_vec && valid_cycles <= stall_cycles) dut_ready = 1'b0;
            if (hs_idx == spur_vec && valid_cycles == 1) begin
                res_valid = 1'b1;
                res_data  = ~dut_data;
            end
            if (dut_ready) begin
                check("sb_nonempty", sb_q.size() != 0, 1'b1);
                if (sb_q.size() != 0) check("issued_stim", dut_data, sb_q.pop_front());
                if (hs_idx == stall_vec) check("stall_valid_cycles", valid_cycles, stall_cycles + 1);
                if (hs_idx == delay_vec) begin
                    if (delay_len > 0) begin
                        pend_cnt  = delay_len;
                        pend_data = dut_data;
                    end
                end else begin
                    pend_cnt  = 1;
                    pend_data = dut_data;
                end
                hs_idx++;
                valid_cycles = 0;
                just_hs = 1'b1;
            end
        end
    end

    typedef struct {
        string         name;
        logic [DW-1:0] pattern;
        int            corrupt_idx;
        logic [DW-1:0] corrupt_xor;
        int            stall_vec;
        int            stall_cycles;
        int            delay_vec;
        int            delay_len;
        int            spur_vec;
        int            exp_cycles;
        logic          exp_pass;
        logic          exp_timeout;
        int            exp_tc;
        int            exp_fc;
        int            exp_lfi;
        int            exp_issues;
    } row_t;

    task automatic setup_run(input row_t r);
        for (int i = 0; i < 64; i++) begin
            rom_stim[i] = r.pattern ^ DW'(i);
            rom_exp[i]  = rom_stim[i];
        end
        if (r.corrupt_idx >= 0) rom_exp[r.corrupt_idx] = rom_exp[r.corrupt_idx] ^ r.corrupt_xor;
        stall_vec    = r.stall_vec;
        stall_cycles = r.stall_cycles;
        delay_vec    = r.delay_vec;
        delay_len    = r.delay_len;
        spur_vec     = r.spur_vec;
        hs_idx       = 0;
        valid_cycles = 0;
        pend_cnt     = 0;
        just_hs      = 1'b0;
        sb_q.delete();
        for (int i = 0; i < r.exp_issues; i++) sb_q.push_back(rom_stim[i]);
    endtask

    task automatic run_row(input row_t r);
        int cycles;
        setup_run(r);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({r.name, ":busy_after_start"}, busy, 1'b1);
        check({r.name, ":done_cleared"}, done, 1'b0);
        cycles = 0;
        while (!done && cycles < 300) begin
            @(negedge clk);
            cycles++;
        end
        check({r.name, ":cycles_to_done"}, cycles, r.exp_cycles);
        check({r.name, ":done"}, done, 1'b1);
        check({r.name, ":busy"}, busy, 1'b0);
        check({r.name, ":pass"}, pass, r.exp_pass);
        check({r.name, ":fail"}, fail, !r.exp_pass);
        check({r.name, ":timeout_flag"}, timeout_flag, r.exp_timeout);
        check({r.name, ":test_count"}, test_count, r.exp_tc);
        check({r.name, ":fail_count"}, fail_count, r.exp_fc);
        check({r.name, ":last_fail_index"}, last_fail_index, r.exp_lfi);
        repeat (4) @(negedge clk);
        check({r.name, ":done_held"}, done, 1'b1);
        check({r.name, ":test_count_held"}, test_count, r.exp_tc);
        check({r.name, ":fail_count_held"}, fail_count, r.exp_fc);
        check({r.name, ":handshakes"}, hs_idx, r.exp_issues);
        check({r.name, ":sb_drained"}, sb_q.size(), 0);
    endtask

    row_t rows [9];

    initial begin
        row_t rr;
        int   waited;

        rows[0] = '{"identity",  32'h0000_0000, -1, 32'h0,         -1, 0, -1, 0, -1, 20, 1'b1, 1'b0, 4, 0, 0, 4};
        rows[1] = '{"corrupt2",  32'h0000_0000,  2, 32'hDEAD_BEED, -1, 0, -1, 0, -1, 20, 1'b0, 1'b0, 4, 1, 2, 4};
        rows[2] = '{"rerun",     32'h5A5A_0000, -1, 32'h0,         -1, 0, -1, 0, -1, 20, 1'b1, 1'b0, 4, 0, 0, 4};
        rows[3] = '{"stall1",    32'hC3C3_1000, -1, 32'h0,          1, 7, -1, 0, -1, 27, 1'b1, 1'b0, 4, 0, 0, 4};
        rows[4] = '{"timeout3",  32'h0F0F_2000, -1, 32'h0,         -1, 0,  3, 0, -1, 26, 1'b0, 1'b1, 4, 1, 3, 4};
        rows[5] = '{"expiry1",   32'h7777_3000, -1, 32'h0,         -1, 0,  1, 8, -1, 27, 1'b1, 1'b0, 4, 0, 0, 4};
        rows[6] = '{"late2",     32'h1111_4000, -1, 32'h0,         -1, 0,  2, 9, -1, 21, 1'b0, 1'b1, 3, 1, 2, 3};
        rows[7] = '{"spur2_msb", 32'hF00D_5000,  0, 32'h8000_0000, -1, 0, -1, 0,  2, 20, 1'b0, 1'b0, 4, 1, 0, 4};
        rows[8] = '{"spur_stall",32'hA5A5_6000, -1, 32'h0,          1, 3, -1, 0,  1, 23, 1'b1, 1'b0, 4, 0, 0, 4};

        for (int i = 0; i < 64; i++) begin
            rom_stim[i] = '0;
            rom_exp[i]  = '0;
        end

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset:busy", busy, 1'b0);
        check("reset:done", done, 1'b0);
        check("reset:pass_fail", {pass, fail}, 2'b00);
        check("reset:dut_valid", dut_valid, 1'b0);
        check("reset:counts", {test_count, fail_count}, '0);
        check("zero:idle_done", z_done, 1'b0);

        // NUM_TESTS = 0: straight to DONE with pass in one cycle.
        z_start = 1'b1;
        @(negedge clk);
        z_start = 1'b0;
        check("zero:done", z_done, 1'b1);
        check("zero:pass", z_pass, 1'b1);
        check("zero:fail", z_fail, 1'b0);
        check("zero:busy", z_busy, 1'b0);
        check("zero:test_count", z_test_count, 0);

        for (int i = 0; i < 9; i++) run_row(rows[i]);

        // Reset while waiting for vector 2's result; vector 1 is a recorded mismatch.
        rr = '{"rst_mid", 32'h1234_0000, 1, 32'h1, -1, 0, 2, 0, -1, 0, 1'b0, 1'b0, 0, 0, 0, 3};
        setup_run(rr);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waited = 0;
        while (hs_idx < 3 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("rst_mid:reached_vec2", hs_idx, 3);
        @(negedge clk);
        check("rst_mid:pre_busy", busy, 1'b1);
        check("rst_mid:pre_test_count", test_count, 2);
        check("rst_mid:pre_fail_count", fail_count, 1);
        check("rst_mid:pre_last_fail", last_fail_index, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid:vec_addr", vec_addr, 0);
        check("rst_mid:dut_valid_data", {dut_valid, dut_data}, '0);
        check("rst_mid:flags", {busy, done, pass, fail, timeout_flag}, 5'b0);
        check("rst_mid:test_count", test_count, 0);
        check("rst_mid:fail_count", fail_count, 0);
        check("rst_mid:last_fail", last_fail_index, 0);
        pend_cnt = 0;
        repeat (2) @(negedge clk);
        check("rst_mid:stays_idle", {busy, done}, 2'b00);

        run_row(rows[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got no end, expected end by 200000");
        $fatal(1);
    end

endmodule
